// File: rtl/gmii_rx_interface_pkg.sv
// gmii_rx_interface_pkg: shared GMII receive constants and FSM state encodings
package gmii_rx_interface_pkg;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_DEFAULT = 8'hD5;
  localparam int WC_W = 11;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_BODY     = 3'd2,
    S_DROP     = 3'd3,
    S_HANDOFF  = 3'd4,
    S_ACK_LOW  = 3'd5
  } state_t;
endpackage

// File: rtl/gmii_rx_interface_sync_3ff.sv
// sync_3ff: three-flop synchroniser for a single asynchronous level
module sync_3ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [2:0] s;
  // shift the asynchronous level through three flops
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= '0;
    else s <= {s[1:0], d};
  assign q = s[2];
endmodule

// File: rtl/gmii_rx_interface.sv
// gmii_rx_interface: strips preamble/SFD, writes frame body to a packet FIFO, hands off byte count
module gmii_rx_interface
  import gmii_rx_interface_pkg::*;
#(
  parameter int MIN_PREAMBLE = 3,
  parameter logic [7:0] SFD_BYTE = SFD_DEFAULT,
  parameter int MAX_BYTES = 2048
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      gmii_rx_data,
  input  logic            gmii_rx_dv,
  input  logic            gmii_rx_er,
  output logic [7:0]      fifo_data,
  output logic            fifo_wr,
  input  logic            fifo_full,
  output logic            fifo_commit,
  output logic            fifo_abort,
  output logic [WC_W-1:0] word_count,
  output logic            word_count_ready,
  input  logic            word_count_ack,
  output logic            rx_error
);
  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam logic [2:0] MIN_PRE = 3'(MIN_PREAMBLE);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);
  logic [7:0] d_q;
  logic dv_q, er_q, ack_sync;
  state_t state, state_n;
  logic [2:0] pre_cnt, pre_n;
  logic [CW-1:0] cnt, cnt_n;
  logic wr_n, commit_n, abort_n, err_n, rdy_n;
  logic [WC_W-1:0] wc_n;
  sync_3ff u_ack_sync (.clk(clk), .rst(rst), .d(word_count_ack), .q(ack_sync));
  // register the GMII pins once before the FSM looks at them
  always_ff @(posedge clk or posedge rst)
    if (rst) {d_q, dv_q, er_q} <= '0;
    else {d_q, dv_q, er_q} <= {gmii_rx_data, gmii_rx_dv, gmii_rx_er};
  // next-state and registered-output decisions for the receive FSM
  always_comb begin
    state_n = state;
    pre_n = pre_cnt;
    cnt_n = cnt;
    wr_n = 1'b0;
    commit_n = 1'b0;
    abort_n = 1'b0;
    err_n = 1'b0;
    wc_n = word_count;
    rdy_n = word_count_ready;
    case (state)
      S_IDLE: if (dv_q) begin
        state_n = d_q == PREAMBLE_BYTE ? S_PREAMBLE : S_DROP;
        pre_n = 3'd1;
      end
      S_PREAMBLE:
        if (!dv_q || er_q) state_n = S_DROP;
        else if (d_q == PREAMBLE_BYTE) pre_n = pre_cnt == 3'd7 ? pre_cnt : pre_cnt + 3'd1;
        else if (d_q == SFD_BYTE && pre_cnt >= MIN_PRE) begin
          state_n = S_BODY;
          cnt_n = '0;
        end else state_n = S_DROP;
      S_BODY:
        if (!dv_q) begin
          if (cnt == '0) begin
            abort_n = 1'b1;
            err_n = 1'b1;
            state_n = S_IDLE;
          end else begin
            commit_n = 1'b1;
            wc_n = WC_W'(cnt - 1'b1);
            rdy_n = 1'b1;
            state_n = S_HANDOFF;
          end
        end else if (er_q || fifo_full || cnt == MAX_CNT) begin
          abort_n = 1'b1;
          err_n = 1'b1;
          state_n = S_DROP;
        end else begin
          wr_n = 1'b1;
          cnt_n = cnt + 1'b1;
        end
      S_DROP: if (!dv_q) state_n = S_IDLE;
      S_HANDOFF: if (ack_sync) begin
        rdy_n = 1'b0;
        state_n = S_ACK_LOW;
      end
      S_ACK_LOW: if (!ack_sync && !dv_q) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  // state, counters and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      pre_cnt <= '0;
      cnt <= '0;
      fifo_data <= '0;
      fifo_wr <= 1'b0;
      fifo_commit <= 1'b0;
      fifo_abort <= 1'b0;
      rx_error <= 1'b0;
      word_count <= '0;
      word_count_ready <= 1'b0;
    end else begin
      state <= state_n;
      pre_cnt <= pre_n;
      cnt <= cnt_n;
      fifo_data <= wr_n ? d_q : fifo_data;
      fifo_wr <= wr_n;
      fifo_commit <= commit_n;
      fifo_abort <= abort_n;
      rx_error <= err_n;
      word_count <= wc_n;
      word_count_ready <= rdy_n;
    end
endmodule

// File: tb/tb_gmii_rx_interface.sv
// tb_gmii_rx_interface: scoreboard bench for the GMII receive front end
module tb_gmii_rx_interface;
  import gmii_rx_interface_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] gmii_rx_data = '0;
  logic gmii_rx_dv = 1'b0, gmii_rx_er = 1'b0, fifo_full = 1'b0, word_count_ack = 1'b0;
  logic [7:0] fifo_data;
  logic fifo_wr, fifo_commit, fifo_abort, word_count_ready, rx_error;
  logic [10:0] word_count;
  int n_checks = 0, n_fail = 0;
  int commits = 0, aborts = 0, errs = 0;
  int exp_commit = 0, exp_abort = 0, exp_err = 0;
  logic [7:0] sb[$];
  gmii_rx_interface dut (
    .clk(clk), .rst(rst), .gmii_rx_data(gmii_rx_data), .gmii_rx_dv(gmii_rx_dv),
    .gmii_rx_er(gmii_rx_er), .fifo_data(fifo_data), .fifo_wr(fifo_wr), .fifo_full(fifo_full),
    .fifo_commit(fifo_commit), .fifo_abort(fifo_abort), .word_count(word_count),
    .word_count_ready(word_count_ready), .word_count_ack(word_count_ack), .rx_error(rx_error)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (fifo_wr | fifo_commit | fifo_abort)
      check("excl", 32'(fifo_wr) + 32'(fifo_commit) + 32'(fifo_abort), 1);
    if (fifo_wr) begin
      if (sb.size() == 0) check("wr_unexpected", 1, 0);
      else check("data", fifo_data, sb.pop_front());
    end
    commits += int'(fifo_commit);
    aborts += int'(fifo_abort);
    errs += int'(rx_error);
  end
  task automatic drive(input logic [7:0] d, input logic dv, input logic er);
    gmii_rx_data = d;
    gmii_rx_dv = dv;
    gmii_rx_er = er;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
  endtask
  task automatic send_frame(input int npre, input int nbody, input int er_at, input int full_at,
                            input int nwr, input logic [7:0] base);
    for (int i = 0; i < npre; i++) drive(PREAMBLE_BYTE, 1'b1, 1'b0);
    drive(SFD_DEFAULT, 1'b1, 1'b0);
    for (int i = 1; i <= nbody; i++) begin
      logic [7:0] b;
      b = base + 8'(i - 1);
      if (i <= nwr) sb.push_back(b);
      fifo_full = full_at > 0 && i > full_at;
      drive(b, 1'b1, i == er_at);
    end
    fifo_full = 1'b0;
    idle(4);
  endtask
  task automatic check_events(input string tag);
    check({tag, "_commit"}, commits, exp_commit);
    check({tag, "_abort"}, aborts, exp_abort);
    check({tag, "_rxerr"}, errs, exp_err);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask
  task automatic do_ack(input string tag, input logic [10:0] exp_wc);
    check({tag, "_ready"}, word_count_ready, 1);
    check({tag, "_wc"}, word_count, exp_wc);
    word_count_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_ready_drop"}, word_count_ready, 0);
    word_count_ack = 1'b0;
    idle(6);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {fifo_data, fifo_wr, fifo_commit, fifo_abort, word_count,
                          word_count_ready, rx_error}, 0);
    check("rst_state", dut.state, S_IDLE);
    rst = 1'b0;
    idle(3);
    send_frame(7, 60, 0, 0, 60, 8'h00);
    exp_commit = 1;
    check_events("t1");
    do_ack("t1", 11'd59);
    send_frame(2, 10, 0, 0, 0, 8'h40);
    check_events("t2");
    check("t2_state", dut.state, S_IDLE);
    check("t2_ready", word_count_ready, 0);
    send_frame(7, 20, 12, 0, 11, 8'h10);
    exp_abort = 1;
    exp_err = 1;
    check_events("t3");
    check("t3_ready", word_count_ready, 0);
    send_frame(7, 30, 0, 0, 30, 8'h80);
    exp_commit = 2;
    check_events("t3b");
    do_ack("t3b", 11'd29);
    send_frame(7, 100, 0, 5, 4, 8'h20);
    exp_abort = 2;
    exp_err = 2;
    check_events("t4_full");
    send_frame(7, 2049, 0, 0, 2048, 8'h00);
    exp_abort = 3;
    exp_err = 3;
    check_events("t4_max");
    check("t4_ready", word_count_ready, 0);
    send_frame(7, 64, 0, 0, 64, 8'h33);
    exp_commit = 3;
    check_events("t5a");
    send_frame(7, 10, 0, 0, 0, 8'hAA);
    check_events("t5b");
    do_ack("t5b", 11'd63);
    send_frame(7, 1, 0, 0, 1, 8'h5A);
    exp_commit = 4;
    check_events("t5c");
    do_ack("t5c", 11'd0);
    for (int i = 0; i < 7; i++) drive(PREAMBLE_BYTE, 1'b1, 1'b0);
    drive(SFD_DEFAULT, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) sb.push_back(8'(8'hC0 + i));
      drive(8'(8'hC0 + i), 1'b1, 1'b0);
    end
    rst = 1'b1;
    #1;
    check("t6_async_outputs", {fifo_data, fifo_wr, fifo_commit, fifo_abort, word_count,
                               word_count_ready, rx_error}, 0);
    check("t6_state", dut.state, S_IDLE);
    idle(2);
    rst = 1'b0;
    idle(2);
    check_events("t6");
    send_frame(7, 16, 0, 0, 16, 8'h70);
    exp_commit = 5;
    check_events("t6b");
    do_ack("t6b", 11'd15);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
